// File: rtl/melody_sequencer.sv
// Melody ROM walker: emits note_code/note_on per ROM entry, each lasting length*TICK_DIV clocks.
// Latency: note_on rises 2 clocks after the edge that samples start; every note adds FETCH+LOAD overhead.
// No backpressure: the tone generator consumes note_code/note_on as levels; stop aborts at once.
module melody_sequencer #(
   parameter int TICK_DIV  = 750000,
   parameter int ADDR_W    = 5,
   parameter int GAP_TICKS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [9:0]        rom_data,
   output logic [5:0]        note_code,
   output logic              note_on,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_PLAY  = 2'd3;

   localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   TICK_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0]      GAP      = 4'(GAP_TICKS);
   localparam logic [4:0]      GAP1     = 5'(GAP_TICKS + 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   logic [1:0]    state;
   logic [PW-1:0] prescaler;
   logic [3:0]    remaining;
   logic          gap_ok;
   logic          wrap_end;

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rom_addr  <= '0;
         note_code <= '0;
         note_on   <= 1'b0;
         done      <= 1'b0;
         prescaler <= '0;
         remaining <= '0;
         gap_ok    <= 1'b0;
         wrap_end  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            note_code <= '0;
            note_on   <= 1'b0;
            prescaler <= '0;
            remaining <= '0;
            wrap_end  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  rom_addr <= '0;
                  if (start) state <= S_FETCH;
               end
               S_FETCH: state <= S_LOAD;
               S_LOAD: begin
                  wrap_end <= 1'b0;
                  // An address wrap arrives here with stale rom_data; it ends the song like a marker.
                  if (wrap_end || rom_data[3:0] == 4'd0) begin
                     rom_addr <= '0;
                     if (loop_en) begin
                        state <= S_FETCH;
                     end else begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end
                  end else begin
                     note_code <= rom_data[9:4];
                     remaining <= rom_data[3:0];
                     prescaler <= '0;
                     note_on   <= |rom_data[9:4];
                     gap_ok    <= rom_data[3:0] > GAP;
                     state     <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (prescaler == TICK_MAX) begin
                     prescaler <= '0;
                     if (remaining == 4'd1) begin
                        note_on <= 1'b0;
                        if (rom_addr == ADDR_MAX) begin
                           rom_addr <= '0;
                           wrap_end <= 1'b1;
                           state    <= S_LOAD;
                        end else begin
                           rom_addr <= rom_addr + 1'b1;
                           state    <= S_FETCH;
                        end
                     end else begin
                        remaining <= remaining - 4'd1;
                        // Entering the trailing GAP_TICKS of the note: silence it for articulation.
                        if (gap_ok && {1'b0, remaining} == GAP1) note_on <= 1'b0;
                     end
                  end else begin
                     prescaler <= prescaler + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
